// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - data-memory req/gnt/rvalid bus between the LSU and data memory
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32I MEM stage: issues loads/stores, steers lanes, extends loads, stalls while busy
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   memRead_In,
  input  logic                   memWrite_In,
  input  logic [2:0]             funct3_In,
  input  logic [31:0]            aluOut_In,
  input  logic [31:0]            storeD_In,
  input  logic                   regWrite_In,
  input  logic                   memToRegWrite_In,
  input  logic [4:0]             rd_In,
  input  logic                   hold_In,
  mem_stage_lsu_if.master        dmem,
  output logic                   stall_Mem,
  output logic [31:0]            readD_Mem,
  output logic [31:0]            aluOut_Mem,
  output logic [4:0]             rd_Mem,
  output logic                   regWrite_Mem,
  output logic                   memToRegWrite_Mem,
  output logic                   fault_Mem,
  output logic [1:0]             faultCause_Mem
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] cap_q, cap_d;

  logic        op_present, is_store, illegal, misaligned;
  logic [1:0]  size, off;
  logic [3:0]  be_lanes;
  logic [31:0] wdata_lanes, shifted, load_ext;
  logic        req, busy, finish, flt, timeout_hit;
  logic [1:0]  cause;
  logic [31:0] rdata_o;

  // Both read and write asserted is treated as a load.
  assign op_present  = memRead_In | memWrite_In;
  assign is_store    = memWrite_In & ~memRead_In;
  assign size        = funct3_In[1:0];
  assign off         = aluOut_In[1:0];
  assign illegal     = (funct3_In == 3'b011) || (funct3_In == 3'b110) || (funct3_In == 3'b111);
  assign misaligned  = ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));
  assign timeout_hit = (cnt_q == CNT_LAST);
  assign shifted     = dmem.dmem_rdata >> {off, 3'b000};

  always_comb begin
    be_lanes    = 4'b1111;
    wdata_lanes = storeD_In;
    case (size)
      2'b00: begin
        be_lanes    = 4'b0001 << off;
        wdata_lanes = {4{storeD_In[7:0]}};
      end
      2'b01: begin
        be_lanes    = off[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{storeD_In[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_ext = shifted;
    case (funct3_In)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    req     = 1'b0;
    busy    = 1'b0;
    finish  = 1'b0;
    flt     = 1'b0;
    cause   = 2'b00;
    rdata_o = '0;
    case (state_q)
      S_IDLE, S_REQ: begin
        if (state_q == S_REQ || (op_present && !illegal && !misaligned)) begin
          req = 1'b1;
          if (dmem.dmem_gnt) begin
            if (is_store) begin
              finish = 1'b1;
            end else if (dmem.dmem_rvalid) begin
              finish  = 1'b1;
              rdata_o = load_ext;
              cap_d   = load_ext;
            end else begin
              state_d = S_RESP;
              cnt_d   = '0;
              busy    = 1'b1;
            end
          end else if (state_q == S_IDLE) begin
            state_d = S_REQ;
            cnt_d   = '0;
            busy    = 1'b1;
          end else if (timeout_hit) begin
            req    = 1'b0;
            flt    = 1'b1;
            cause  = 2'b11;
            cap_d  = '0;
            finish = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
            busy  = 1'b1;
          end
        end else if (op_present) begin
          flt    = 1'b1;
          cause  = illegal ? 2'b10 : 2'b01;
          cap_d  = '0;
          finish = 1'b1;
        end
      end
      S_RESP: begin
        if (dmem.dmem_rvalid) begin
          finish  = 1'b1;
          rdata_o = load_ext;
          cap_d   = load_ext;
        end else if (timeout_hit) begin
          flt    = 1'b1;
          cause  = 2'b11;
          cap_d  = '0;
          finish = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          busy  = 1'b1;
        end
      end
      S_DONE: begin
        // Completed access parked while the pipeline is held; never reissued.
        rdata_o = cap_q;
        if (!hold_In) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (finish) state_d = hold_In ? S_DONE : S_IDLE;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
    end
  end

  // Every output is forced low while reset is asserted, including the request.
  assign dmem.dmem_req      = rstN & req;
  assign dmem.dmem_we       = rstN & is_store;
  assign dmem.dmem_addr     = rstN ? {aluOut_In[31:2], 2'b00} : '0;
  assign dmem.dmem_be       = rstN ? be_lanes : '0;
  assign dmem.dmem_wdata    = rstN ? wdata_lanes : '0;

  assign stall_Mem          = rstN & busy;
  assign readD_Mem          = rstN ? rdata_o : '0;
  assign aluOut_Mem         = rstN ? aluOut_In : '0;
  assign rd_Mem             = rstN ? rd_In : '0;
  assign regWrite_Mem       = rstN & regWrite_In & ~busy & ~flt;
  assign memToRegWrite_Mem  = rstN & memToRegWrite_In & ~busy & ~flt;
  assign fault_Mem          = rstN & flt;
  assign faultCause_Mem     = rstN ? cause : 2'b00;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - randomized self-checking bench for mem_stage_lsu against a behavioural model
module tb_mem_stage_lsu;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        memRead_In = 1'b0, memWrite_In = 1'b0;
  logic [2:0]  funct3_In = '0;
  logic [31:0] aluOut_In = '0, storeD_In = '0;
  logic        regWrite_In = 1'b0, memToRegWrite_In = 1'b0, hold_In = 1'b0;
  logic [4:0]  rd_In = '0;
  logic        stall_Mem, regWrite_Mem, memToRegWrite_Mem, fault_Mem;
  logic [31:0] readD_Mem, aluOut_Mem;
  logic [4:0]  rd_Mem;
  logic [1:0]  faultCause_Mem;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_lsu_if bus ();

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rstN(rstN),
    .memRead_In(memRead_In), .memWrite_In(memWrite_In), .funct3_In(funct3_In),
    .aluOut_In(aluOut_In), .storeD_In(storeD_In), .regWrite_In(regWrite_In),
    .memToRegWrite_In(memToRegWrite_In), .rd_In(rd_In), .hold_In(hold_In),
    .dmem(bus),
    .stall_Mem(stall_Mem), .readD_Mem(readD_Mem), .aluOut_Mem(aluOut_Mem),
    .rd_Mem(rd_Mem), .regWrite_Mem(regWrite_Mem), .memToRegWrite_Mem(memToRegWrite_Mem),
    .fault_Mem(fault_Mem), .faultCause_Mem(faultCause_Mem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // 0 = legal, 1 = misaligned, 2 = illegal funct3
  function automatic int f_cause(logic [2:0] f3, logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 2;
    if ((f3 % 4) == 1 && (a % 2) != 0) return 1;
    if ((f3 % 4) == 2 && (a % 4) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] exp_be(logic [2:0] f3, logic [31:0] a);
    int o;
    o = a % 4;
    if ((f3 % 4) == 0) return 32'(1 << o);
    if ((f3 % 4) == 1) return (o < 2) ? 32'd3 : 32'd12;
    return 32'd15;
  endfunction

  function automatic logic [31:0] exp_wdata(logic [2:0] f3, logic [31:0] d);
    if ((f3 % 4) == 0) return (d % 256) * 32'h0101_0101;
    if ((f3 % 4) == 1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(logic [2:0] f3, logic [31:0] a, logic [31:0] r);
    logic [31:0] w, v;
    w = r >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = w % 256;   return (v >= 128)   ? v + 32'hFFFF_FF00 : v; end
      3'd1: begin v = w % 65536; return (v >= 32768) ? v + 32'hFFFF_0000 : v; end
      3'd4: return w % 256;
      3'd5: return w % 65536;
      default: return w;
    endcase
  endfunction

  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rdat, input int g, input int rv,
                        input bit hold, input int hx);
    bit op, is_ld, is_st, tmo, bad;
    int cause, end_k;
    logic [31:0] ext;
    logic rw_in, m2r_in;
    logic [4:0] rd;
    op = ld | st;
    is_ld = ld;
    is_st = st & !ld;
    cause = op ? f_cause(f3, addr) : 0;
    tmo = 1'b0;
    end_k = 0;
    if (op && cause == 0) begin
      if (g > TO) begin end_k = TO; tmo = 1'b1; end
      else if (is_st) end_k = g;
      else if (rv > TO) begin end_k = g + TO; tmo = 1'b1; end
      else end_k = g + rv;
    end
    bad = (cause != 0) || tmo;
    ext = exp_load(f3, addr, rdat);
    rw_in = 1'($urandom);
    m2r_in = 1'($urandom);
    rd = 5'($urandom);
    @(posedge clk); #1;
    memRead_In = ld; memWrite_In = st; funct3_In = f3; aluOut_In = addr; storeD_In = sd;
    regWrite_In = rw_in; memToRegWrite_In = m2r_in; rd_In = rd; hold_In = hold;
    for (int k = 0; k <= end_k; k++) begin
      bit exp_req;
      exp_req = op && cause == 0 && k <= g && !(tmo && k == end_k);
      bus.dmem_gnt = op && cause == 0 && k == g;
      bus.dmem_rvalid = is_ld && cause == 0 && k == g + rv;
      bus.dmem_rdata = bus.dmem_rvalid ? rdat : $urandom;
      @(negedge clk);
      check("stall", stall_Mem, k < end_k);
      check("req", bus.dmem_req, exp_req);
      if (exp_req) begin
        check("addr", bus.dmem_addr, addr & 32'hFFFF_FFFC);
        check("be", bus.dmem_be, exp_be(f3, addr));
        check("we", bus.dmem_we, is_st);
        if (is_st) check("wdata", bus.dmem_wdata, exp_wdata(f3, sd));
      end
      if (k < end_k) begin
        check("rw_bubble", regWrite_Mem, 0);
        check("m2r_bubble", memToRegWrite_Mem, 0);
        check("fault_early", fault_Mem, 0);
        @(posedge clk); #1;
      end else begin
        check("fault", fault_Mem, op && bad);
        check("cause", faultCause_Mem, !op ? 0 : tmo ? 3 : cause);
        check("rw", regWrite_Mem, (op && bad) ? 1'b0 : rw_in);
        if (!bad) check("m2r", memToRegWrite_Mem, m2r_in);
        if (is_ld && cause == 0) check("readD", readD_Mem, tmo ? 32'd0 : ext);
        check("alu_pass", aluOut_Mem, addr);
        check("rd_pass", rd_Mem, rd);
      end
    end
    if (hold) begin
      for (int h = 0; h <= hx; h++) begin
        @(posedge clk); #1;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
        hold_In = (h < hx);
        @(negedge clk);
        check("done_req", bus.dmem_req, 0);
        check("done_stall", stall_Mem, 0);
        check("done_fault", fault_Mem, 0);
        if (is_ld) check("done_readD", readD_Mem, ext);
      end
    end
    @(posedge clk); #1;
    memRead_In = 1'b0; memWrite_In = 1'b0; hold_In = 1'b0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    regWrite_In = 1'b1; memToRegWrite_In = 1'b1; rd_In = 5'd7; aluOut_In = 32'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", bus.dmem_req, 0);
    check("rst_stall", stall_Mem, 0);
    check("rst_fault", fault_Mem, 0);
    check("rst_readD", readD_Mem, 0);
    check("rst_rw", regWrite_Mem, 0);
    check("rst_m2r", memToRegWrite_Mem, 0);
    check("rst_rd", rd_Mem, 0);
    check("rst_alu", aluOut_Mem, 0);
    @(posedge clk); #1;
    rstN = 1'b1;

    run_op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2, 0, 0, 0);
    run_op(1, 0, 3'b000, 32'h103, 32'hDEADBEEF, 32'h80FF_FF7F, 0, 1, 0, 0);
    run_op(1, 0, 3'b100, 32'h103, 32'hDEADBEEF, 32'h80FF_FF7F, 0, 1, 0, 0);
    run_op(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 1, 0, 0, 0);
    run_op(1, 0, 3'b001, 32'h101, 32'h0, 32'h5555_AAAA, 0, 0, 0, 0);
    run_op(0, 1, 3'b111, 32'h100, 32'h0, 32'h0, 0, 0, 0, 0);
    run_op(0, 1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h0, 1, 0, 1, 3);
    run_op(1, 0, 3'b010, 32'h204, 32'h0, 32'h1111_2222, 2, 3, 1, 2);
    run_op(0, 1, 3'b010, 32'h208, 32'h0, 32'h0, 100, 0, 0, 0);
    run_op(1, 1, 3'b101, 32'h20A, 32'h0, 32'h8765_4321, 1, 1, 0, 0);
    run_op(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 0, 1000, 0, 0);

    // late rvalid with no op present must be ignored
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("late_readD", readD_Mem, 0);
    check("late_fault", fault_Mem, 0);
    check("late_stall", stall_Mem, 0);
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b0;

    // reset while a store is waiting in REQ
    memWrite_In = 1'b1; memRead_In = 1'b0; funct3_In = 3'b010; aluOut_In = 32'h400; storeD_In = 32'h0;
    @(negedge clk);
    check("pre_rst_req", bus.dmem_req, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("req_state_stall", stall_Mem, 1);
    #1 rstN = 1'b0;
    #1;
    check("mid_rst_req", bus.dmem_req, 0);
    check("mid_rst_stall", stall_Mem, 0);
    @(posedge clk); #1;
    memWrite_In = 1'b0;
    rstN = 1'b1;
    @(negedge clk);
    check("post_rst_req", bus.dmem_req, 0);
    check("post_rst_stall", stall_Mem, 0);
    run_op(0, 1, 3'b000, 32'h401, 32'h0000_00A5, 32'h0, 0, 0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      int kind, o, sz, g, rv, hx;
      bit ld, st, hold;
      logic [2:0] f3;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      ld = (kind >= 1 && kind <= 5);
      st = (kind >= 6) || (ld && $urandom_range(0, 7) == 0);
      if (ld) f3 = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 3'd3 : 3'd6)
                                               : 3'($urandom_range(0, 4) + (($urandom_range(0, 1) == 0) ? 0 : 0));
      else    f3 = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 2));
      if (ld && f3 == 3'd3 && $urandom_range(0, 1) == 0) f3 = 3'd4;
      if (ld && f3 <= 3'd4 && f3 >= 3'd3 && $urandom_range(0, 3) == 0) f3 = 3'd5;
      sz = f3 % 4;
      o = $urandom_range(0, 3);
      if ($urandom_range(0, 4) != 0 || f3 == 3 || f3 >= 6) begin
        if (sz == 1) o = o & 2;
        else if (sz >= 2) o = 0;
      end
      a = ($urandom & 32'hFFFF_FFFC) | 32'(o);
      g = $urandom_range(0, 3);
      rv = $urandom_range(0, 3);
      hold = (ld || st) && f_cause(f3, a) == 0 && $urandom_range(0, 4) == 0;
      hx = $urandom_range(1, 2);
      run_op(ld, st, f3, a, $urandom, $urandom, g, rv, hold, hx);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Issues loads and stores to the data memory over a req/gnt/rvalid handshake.
- Performs store byte-lane steering, load extraction and sign/zero extension, and misalignment checks.
- Stalls the pipeline while an access is outstanding. Forwards ALU result, rd and writeback controls to MEM/WB.

Parameters:
- TIMEOUT, 16, cycles without gnt (in REQ) or rvalid (in RESP) before a bus error is declared; range 2..255.

Ports:
- clk  in  1  clock
- rstN  in  1  asynchronous active-low reset
- memRead_In  in  1  load in MEM stage
- memWrite_In  in  1  store in MEM stage
- funct3_In  in  3  access size/sign (RV32I encoding)
- aluOut_In  in  32  effective address / ALU result
- storeD_In  in  32  rs2 store data
- regWrite_In  in  1  writeback enable from control
- memToRegWrite_In  in  1  select memory data at writeback
- rd_In  in  regName_t  destination register
- hold_In  in  1  external stall from hazard unit (EX/MEM held for non-memory reasons)
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address (aluOut_In with bits [1:0] = 0)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-steered store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read word
- stall_Mem  out  1  MEM stage not complete; hold PC/IF/ID/EX/MEM
- readD_Mem  out  32  extended load data to MEM/WB
- aluOut_Mem  out  32  aluOut_In passthrough
- rd_Mem  out  regName_t  rd_In passthrough
- regWrite_Mem  out  1  writeback enable to MEM/WB (bubble-gated)
- memToRegWrite_Mem  out  1  to MEM/WB (bubble-gated)
- fault_Mem  out  1  one-cycle pulse: misaligned, illegal funct3 or bus timeout
- faultCause_Mem  out  2  01 misaligned, 10 illegal funct3, 11 timeout; 00 when no fault

Behaviour:
- Reset (async, rstN=0): FSM to IDLE, timeout counter 0, captured-data register 0. All outputs are 0 and rd_Mem = zero for as long as rstN=0 with no op present. A reset in mid-transaction abandons it; no gnt/rvalid is consumed afterwards.
- Op present = memRead_In | memWrite_In. If both are 1, treat as a load.
- Legality check, combinational in IDLE:
  - funct3 011/110/111, or funct3 111 on a store: illegal.
  - Halfword with addr[0]=1, or word with addr[1:0]≠0: misaligned.
  - An illegal or misaligned op issues no request, completes in 0 extra cycles, pulses fault_Mem and forces regWrite_Mem=0.
- Store lanes:
  - SB: be = 1<<addr[1:0], wdata = {4{byte}}.
  - SH: be = 0011 or 1100 by addr[1], wdata = {2{half}}.
  - SW: be = 1111.
- Load extraction by addr[1:0]: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word. dmem_be for loads follows the same lane rule.
- States:
  - IDLE:
    - No op: stall_Mem=0, outputs pass through.
    - Legal op: dmem_req=1 combinationally. If gnt in the same cycle, go to RESP (load) or complete (store); otherwise go to REQ. stall_Mem=1 unless the op completes this cycle.
  - REQ: hold dmem_req and all bus fields stable until gnt. On gnt: store completes; load goes to RESP.
  - RESP: wait for rvalid. On rvalid, readD_Mem = extended dmem_rdata in the same cycle, stall_Mem=0, and MEM/WB captures at that edge. The value is also latched into the captured-data register.
  - DONE: entered on completion when hold_In=1. No reissue (stores must never repeat). readD_Mem comes from the captured register. Return to IDLE when hold_In=0.
- Completion: a store completes on the gnt cycle; a load completes on the rvalid cycle. In the completion cycle stall_Mem=0, and regWrite_Mem and memToRegWrite_Mem follow their inputs. rvalid may coincide with gnt only for a zero-wait memory: RESP is skipped if rvalid and gnt are both 1 in IDLE or REQ.
- Bubble rule: whenever stall_Mem=1, regWrite_Mem=0 and memToRegWrite_Mem=0, so the MEM/WB register (no enable) captures a bubble.
- Timeout:
  - The counter clears on entry to REQ or RESP and increments each cycle in those states.
  - At TIMEOUT-1 without the awaited signal: abandon, drop dmem_req, pulse fault_Mem with cause 11, readD_Mem=0, regWrite_Mem=0, stall_Mem=0, then go to IDLE (or DONE if hold_In=1).
  - A late rvalid arriving in IDLE is ignored.
- Non-memory ops: zero latency, no stall, fault_Mem=0.

Test Plan:
- SW to 0x100, data 0xDEADBEEF, gnt after 2 cycles -> req held 3 cycles with be=1111 and wdata stable; stall_Mem=1 for 2 cycles; regWrite_Mem=0 throughout.
- LB from 0x103, rdata 0x80FF_FF7F, gnt same cycle, rvalid 1 cycle later -> readD_Mem=0xFFFFFF80 in the rvalid cycle. LBU at the same address -> 0x00000080.
- SH to 0x102, data 0x1234ABCD -> be=1100, wdata=0xABCDABCD. LH from 0x101 -> no req, fault_Mem pulse with cause 01, regWrite_Mem=0.
- Store completes while hold_In=1 for 3 cycles -> exactly one gnt'd request, FSM stays in DONE, no second dmem_req.
- Load where rvalid never arrives (TIMEOUT=16) -> fault_Mem with cause 11 in the 16th RESP cycle, stall drops, readD_Mem=0.
- rstN asserted low while in REQ -> dmem_req=0 immediately, stall_Mem=0. After release with no op present, the FSM is in IDLE.
